servant_spi_cache: RTL and testbench
====================================

Name: servant_spi_cache

Overview:
- Direct-mapped, write-through word cache between the servile memory Wishbone port and the SPI master interface.
- Serves repeated instruction and data reads without a multi-hundred-cycle SPI round trip.
- Forwards every write downstream; on a write hit it also updates the cached copy.
- Upstream side is a Wishbone slave driven by the CPU; downstream side is a Wishbone master feeding the SPI master interface.

Parameters:
- AW, 22, word-address width (CPU byte address bits [AW+1:2]).
- LINES, 16, number of cache lines, power of two ≥ 2; one 32-bit word per line.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  synchronous reset, active low.
- i_wb_cpu_adr  in  AW  CPU word address.
- i_wb_cpu_dat  in  32  CPU write data.
- i_wb_cpu_sel  in  4  CPU byte enables.
- i_wb_cpu_we  in  1  CPU write.
- i_wb_cpu_cyc  in  1  CPU request, held until ack.
- o_wb_cpu_rdt  out  32  read data, valid with ack.
- o_wb_cpu_ack  out  1  one-cycle acknowledge.
- o_wb_mem_adr  out  AW  downstream word address.
- o_wb_mem_dat  out  32  downstream write data.
- o_wb_mem_sel  out  4  downstream byte enables.
- o_wb_mem_we  out  1  downstream write.
- o_wb_mem_cyc  out  1  downstream request.
- i_wb_mem_rdt  in  32  downstream read data.
- i_wb_mem_ack  in  1  downstream acknowledge.

Behaviour:
- Reset (i_rst_n low at a rising edge):
  - All valid bits cleared; state goes to IDLE.
  - o_wb_cpu_ack, o_wb_mem_cyc, o_wb_mem_we = 0.
  - o_wb_cpu_rdt, o_wb_mem_adr, o_wb_mem_dat, o_wb_mem_sel = 0.
  - Tag and data arrays are not reset.
- Address split: index = adr[log2(LINES)-1:0]; tag = adr[AW-1:log2(LINES)]. Hit = valid[index] and tag match.
- States:
  - IDLE: accept a request when i_wb_cpu_cyc=1 and o_wb_cpu_ack=0. A request is never accepted in the cycle ack is high, so each CPU transfer gets exactly one ack.
  - Read hit: stay in IDLE. Next cycle: o_wb_cpu_ack=1 and o_wb_cpu_rdt = cached word. Latency 1 cycle.
  - Read miss: register adr, set o_wb_mem_sel=4'hF, o_wb_mem_we=0, o_wb_mem_cyc=1; go to FILL.
  - Write: register adr/dat/sel, set o_wb_mem_we=1, o_wb_mem_cyc=1; go to WRITE. Valid bits and tags are unchanged.
  - FILL: hold all downstream outputs stable until i_wb_mem_ack. On the ack cycle:
    - write i_wb_mem_rdt into data[index], set tag[index], set valid[index]=1;
    - drop o_wb_mem_cyc;
    - next cycle o_wb_cpu_ack=1 and o_wb_cpu_rdt = filled word;
    - return to IDLE.
  - WRITE: hold downstream outputs until i_wb_mem_ack. On the ack cycle:
    - if the line hits, merge the bytes enabled in sel into data[index]; on a miss, no allocation;
    - drop o_wb_mem_cyc and o_wb_mem_we;
    - next cycle o_wb_cpu_ack=1, o_wb_cpu_rdt=0;
    - return to IDLE.
- Request/ack handshake:
  - o_wb_cpu_ack is high for exactly one cycle per transfer.
  - o_wb_mem_cyc is deasserted in the cycle after i_wb_mem_ack.
  - At most one downstream transaction is outstanding.
- A stray i_wb_mem_ack while in IDLE is ignored.
- Reset during FILL or WRITE:
  - Abandon the transaction; no array update, no CPU ack.
  - Downstream cyc drops at the reset edge.
- Read data on a miss always comes from the downstream port, never from stale array contents.

Optional Feature:
- Macro: SPI_CACHE_STATS_EN.
- Defined: adds outputs o_hits[15:0] and o_misses[15:0].
  - o_hits increments on each read hit at acceptance.
  - o_misses increments on each read miss at acceptance.
  - Both saturate at 16'hFFFF and reset to 0.
  - Writes count toward neither.
- Undefined: ports and counters are absent. Functional behaviour is identical.

Test Plan:
- Cold read adr=0x000010; downstream returns 0xDEADBEEF with ack after 40 cycles -> one downstream read (sel=F, we=0); CPU ack 1 cycle after mem ack, rdt=0xDEADBEEF.
- Repeat read adr=0x000010 -> no o_wb_mem_cyc; ack on cycle 1 after acceptance, rdt=0xDEADBEEF; with STATS hits=1, misses=1.
- Write adr=0x000010, dat=0x11223344, sel=4'b0011, then read same adr -> downstream write with the same dat/sel; read hits with rdt=0xDEAD3344.
- Conflict: read 0x000010, then read 0x000020 (same index 0 for LINES=16), then read 0x000010 -> three downstream reads (eviction); write to an uncached adr leaves a following read as a miss.
- Assert i_rst_n=0 during a FILL for one cycle, then complete mem ack -> no CPU ack, o_wb_mem_cyc=0 after the reset edge; the next read of that adr misses.
- Back-to-back: CPU holds cyc through ack and re-presents a new adr the next cycle -> exactly one ack per transfer, never two consecutive ack cycles.

Source files
------------

// File: rtl/servant_spi_cache.sv
// servant_spi_cache
// Direct-mapped, write-through, one-word-per-line cache sitting between the
// servile CPU memory Wishbone port and the SPI master Wishbone port. Repeated
// reads are served in one cycle from the local arrays; every write is passed
// downstream and, when it hits, also merged into the cached copy.
//
// Ports
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_wb_cpu_*            Wishbone slave from the CPU (cyc held until ack)
//   o_wb_cpu_rdt/ack      read data and one-cycle acknowledge to the CPU
//   o_wb_mem_*            Wishbone master towards the SPI master interface
//   i_wb_mem_rdt/ack      downstream read data and acknowledge
//   o_hits, o_misses      read hit/miss counters (SPI_CACHE_STATS_EN only)
//
// Build option: define SPI_CACHE_STATS_EN to add the saturating 16-bit
// hit/miss counters. Without it the counters and their ports are absent.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for a CPU request; read hits are answered from here
// S_FILL  | downstream read outstanding for a read miss
// S_WRITE | downstream write outstanding (write-through)

module servant_spi_cache #(
   parameter int AW    = 22,
   parameter int LINES = 16
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic [AW-1:0] i_wb_cpu_adr,
   input  logic [31:0]   i_wb_cpu_dat,
   input  logic [3:0]    i_wb_cpu_sel,
   input  logic          i_wb_cpu_we,
   input  logic          i_wb_cpu_cyc,
   output logic [31:0]   o_wb_cpu_rdt,
   output logic          o_wb_cpu_ack,
   output logic [AW-1:0] o_wb_mem_adr,
   output logic [31:0]   o_wb_mem_dat,
   output logic [3:0]    o_wb_mem_sel,
   output logic          o_wb_mem_we,
   output logic          o_wb_mem_cyc,
   input  logic [31:0]   i_wb_mem_rdt,
   input  logic          i_wb_mem_ack
`ifdef SPI_CACHE_STATS_EN
   ,
   output logic [15:0]   o_hits,
   output logic [15:0]   o_misses
`endif
);

   localparam int IW = $clog2(LINES);
   localparam int TW = AW - IW;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_WRITE
   } state_t;

   state_t           state;
   logic [31:0]      data_q [LINES];
   logic [TW-1:0]    tag_q  [LINES];
   logic [LINES-1:0] valid_q;

   logic [IW-1:0] cpu_idx;
   logic [TW-1:0] cpu_tag;
   logic [IW-1:0] mem_idx;
   logic [TW-1:0] mem_tag;
   logic          cpu_hit;
   logic          mem_hit;
   logic          accept;
   logic          fill_done;
   logic          write_done;
   logic [31:0]   merged;

   assign cpu_idx = i_wb_cpu_adr[IW-1:0];
   assign cpu_tag = i_wb_cpu_adr[AW-1:IW];
   // The registered downstream address identifies the line being filled or written.
   assign mem_idx = o_wb_mem_adr[IW-1:0];
   assign mem_tag = o_wb_mem_adr[AW-1:IW];

   assign cpu_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
   assign mem_hit = valid_q[mem_idx] && (tag_q[mem_idx] == mem_tag);

   // Blocking acceptance while ack is high keeps a held cyc from being
   // counted as a second transfer.
   assign accept     = (state == S_IDLE) && i_wb_cpu_cyc && !o_wb_cpu_ack;
   assign fill_done  = (state == S_FILL)  && i_wb_mem_ack;
   assign write_done = (state == S_WRITE) && i_wb_mem_ack;

   always_comb begin
      merged = data_q[mem_idx];
      for (int b = 0; b < 4; b++) begin
         if (o_wb_mem_sel[b]) merged[8*b +: 8] = o_wb_mem_dat[8*b +: 8];
      end
   end

   // Tag and data arrays carry no reset; only the valid bits qualify them.
   // A reset edge during an outstanding transfer must not touch them.
   always_ff @(posedge i_clk) begin
      if (i_rst_n) begin
         if (fill_done) begin
            data_q[mem_idx] <= i_wb_mem_rdt;
            tag_q[mem_idx]  <= mem_tag;
         end else if (write_done && mem_hit) begin
            data_q[mem_idx] <= merged;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state        <= S_IDLE;
         valid_q      <= '0;
         o_wb_cpu_ack <= 1'b0;
         o_wb_cpu_rdt <= '0;
         o_wb_mem_adr <= '0;
         o_wb_mem_dat <= '0;
         o_wb_mem_sel <= '0;
         o_wb_mem_we  <= 1'b0;
         o_wb_mem_cyc <= 1'b0;
`ifdef SPI_CACHE_STATS_EN
         o_hits       <= '0;
         o_misses     <= '0;
`endif
      end else begin
         o_wb_cpu_ack <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (i_wb_cpu_we) begin
                     o_wb_mem_adr <= i_wb_cpu_adr;
                     o_wb_mem_dat <= i_wb_cpu_dat;
                     o_wb_mem_sel <= i_wb_cpu_sel;
                     o_wb_mem_we  <= 1'b1;
                     o_wb_mem_cyc <= 1'b1;
                     state        <= S_WRITE;
                  end else if (cpu_hit) begin
                     o_wb_cpu_ack <= 1'b1;
                     o_wb_cpu_rdt <= data_q[cpu_idx];
`ifdef SPI_CACHE_STATS_EN
                     if (o_hits != 16'hFFFF) o_hits <= o_hits + 16'd1;
`endif
                  end else begin
                     o_wb_mem_adr <= i_wb_cpu_adr;
                     o_wb_mem_sel <= 4'hF;
                     o_wb_mem_we  <= 1'b0;
                     o_wb_mem_cyc <= 1'b1;
                     state        <= S_FILL;
`ifdef SPI_CACHE_STATS_EN
                     if (o_misses != 16'hFFFF) o_misses <= o_misses + 16'd1;
`endif
                  end
               end
            end
            S_FILL: begin
               if (i_wb_mem_ack) begin
                  valid_q[mem_idx] <= 1'b1;
                  o_wb_mem_cyc     <= 1'b0;
                  o_wb_cpu_ack     <= 1'b1;
                  o_wb_cpu_rdt     <= i_wb_mem_rdt;
                  state            <= S_IDLE;
               end
            end
            S_WRITE: begin
               if (i_wb_mem_ack) begin
                  o_wb_mem_cyc <= 1'b0;
                  o_wb_mem_we  <= 1'b0;
                  o_wb_cpu_ack <= 1'b1;
                  o_wb_cpu_rdt <= '0;
                  state        <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_servant_spi_cache.sv
// Scoreboard bench for servant_spi_cache: a driver issues directed and random
// CPU transfers and pushes the reference-model expectation; a monitor pops and
// compares on every CPU ack. A behavioural downstream memory answers the
// Wishbone master port with configurable latency.

module tb_servant_spi_cache;

   localparam int AW    = 22;
   localparam int LINES = 16;

   logic          clk;
   logic          rst_n;
   logic [AW-1:0] i_wb_cpu_adr;
   logic [31:0]   i_wb_cpu_dat;
   logic [3:0]    i_wb_cpu_sel;
   logic          i_wb_cpu_we;
   logic          i_wb_cpu_cyc;
   logic [31:0]   o_wb_cpu_rdt;
   logic          o_wb_cpu_ack;
   logic [AW-1:0] o_wb_mem_adr;
   logic [31:0]   o_wb_mem_dat;
   logic [3:0]    o_wb_mem_sel;
   logic          o_wb_mem_we;
   logic          o_wb_mem_cyc;
   logic [31:0]   i_wb_mem_rdt;
   logic          i_wb_mem_ack;
`ifdef SPI_CACHE_STATS_EN
   logic [15:0]   o_hits;
   logic [15:0]   o_misses;
`endif

   servant_spi_cache #(.AW(AW), .LINES(LINES)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_wb_cpu_adr (i_wb_cpu_adr),
      .i_wb_cpu_dat (i_wb_cpu_dat),
      .i_wb_cpu_sel (i_wb_cpu_sel),
      .i_wb_cpu_we  (i_wb_cpu_we),
      .i_wb_cpu_cyc (i_wb_cpu_cyc),
      .o_wb_cpu_rdt (o_wb_cpu_rdt),
      .o_wb_cpu_ack (o_wb_cpu_ack),
      .o_wb_mem_adr (o_wb_mem_adr),
      .o_wb_mem_dat (o_wb_mem_dat),
      .o_wb_mem_sel (o_wb_mem_sel),
      .o_wb_mem_we  (o_wb_mem_we),
      .o_wb_mem_cyc (o_wb_mem_cyc),
      .i_wb_mem_rdt (i_wb_mem_rdt),
      .i_wb_mem_ack (i_wb_mem_ack)
`ifdef SPI_CACHE_STATS_EN
      ,
      .o_hits       (o_hits),
      .o_misses     (o_misses)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          we;
      logic          hit;
      logic [AW-1:0] adr;
      logic [31:0]   dat;
      logic [3:0]    sel;
      logic [31:0]   rdt;
      int            starts;
      int            hits;
      int            misses;
   } exp_t;

   exp_t sb[$];

   int errors;
   int checks;
   bit tb_done;

   // ---------------- shared memory contents ----------------
   function automatic logic [31:0] init_word(input int a);
      logic [31:0] x;
      x = a;
      if (a == 16) return 32'hDEADBEEF;
      return (x * 32'h9E3779B1) ^ 32'hA5A50F0F;
   endfunction

   // ---------------- downstream memory model ----------------
   logic [31:0]   slave_mem [int];
   int            mem_delay;
   bit            slv_pending;
   int            slv_cnt;
   int            slv_starts;
   logic [AW-1:0] cap_adr;
   logic [31:0]   cap_dat;
   logic [3:0]    cap_sel;
   logic          cap_we;
   logic [AW-1:0] last_r_adr, last_w_adr;
   logic [3:0]    last_r_sel, last_w_sel;
   logic [31:0]   last_w_dat;

   initial begin
      logic [31:0] w;
      i_wb_mem_ack = 1'b0;
      i_wb_mem_rdt = '0;
      slv_pending  = 1'b0;
      slv_cnt      = 0;
      slv_starts   = 0;
      last_r_adr = '0; last_w_adr = '0; last_r_sel = '0; last_w_sel = '0; last_w_dat = '0;
      forever begin
         @(posedge clk);
         #1;
         i_wb_mem_ack = 1'b0;
         if (slv_pending) begin
            if (slv_cnt == 0) begin
               w = slave_mem.exists(int'(cap_adr)) ? slave_mem[int'(cap_adr)] : init_word(int'(cap_adr));
               if (cap_we) begin
                  for (int b = 0; b < 4; b++)
                     if (cap_sel[b]) w[8*b +: 8] = cap_dat[8*b +: 8];
                  slave_mem[int'(cap_adr)] = w;
                  i_wb_mem_rdt = $urandom;
               end else begin
                  i_wb_mem_rdt = w;
               end
               i_wb_mem_ack = 1'b1;
               slv_pending  = 1'b0;
            end else begin
               slv_cnt--;
            end
         end else if (o_wb_mem_cyc) begin
            slv_pending = 1'b1;
            slv_cnt     = mem_delay;
            cap_adr = o_wb_mem_adr; cap_dat = o_wb_mem_dat;
            cap_sel = o_wb_mem_sel; cap_we  = o_wb_mem_we;
            slv_starts++;
            if (o_wb_mem_we) begin
               last_w_adr = o_wb_mem_adr; last_w_dat = o_wb_mem_dat; last_w_sel = o_wb_mem_sel;
            end else begin
               last_r_adr = o_wb_mem_adr; last_r_sel = o_wb_mem_sel;
            end
         end
      end
   end

   // ---------------- reference model ----------------
   logic [31:0] ref_mem [int];
   int          line_adr [LINES];
   bit          line_ok  [LINES];
   int          m_starts, m_hits, m_misses;

   function automatic logic [31:0] ref_rd(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < LINES; i++) line_ok[i] = 1'b0;
      m_hits = 0;
      m_misses = 0;
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial begin
      bit   prev_rst_low, prev_mem_ack, prev_cpu_ack, abandoned;
      int   wait_c;
      exp_t e;
      errors = 0; checks = 0;
      prev_rst_low = 1'b0; prev_mem_ack = 1'b0; prev_cpu_ack = 1'b0; abandoned = 1'b0;
      wait_c = 0;
      forever begin
         @(negedge clk);
         if (prev_rst_low) begin
            chk("rst_cpu_ack", o_wb_cpu_ack, 0);
            chk("rst_mem_cyc", o_wb_mem_cyc, 0);
            chk("rst_mem_we",  o_wb_mem_we, 0);
            chk("rst_cpu_rdt", o_wb_cpu_rdt, 0);
            chk("rst_mem_adr", o_wb_mem_adr, 0);
            chk("rst_mem_dat", o_wb_mem_dat, 0);
            chk("rst_mem_sel", o_wb_mem_sel, 0);
`ifdef SPI_CACHE_STATS_EN
            chk("rst_hits",   o_hits, 0);
            chk("rst_misses", o_misses, 0);
`endif
         end
         if (!rst_n) begin
            abandoned = 1'b1;
            wait_c = 0;
         end else begin
            if (abandoned && !slv_pending) abandoned = 1'b0;
            if (slv_pending && !abandoned) begin
               chk("mem_cyc_hold", o_wb_mem_cyc, 1);
               chk("mem_adr_hold", o_wb_mem_adr, cap_adr);
               chk("mem_we_hold",  o_wb_mem_we, cap_we);
               chk("mem_sel_hold", o_wb_mem_sel, cap_sel);
               if (cap_we) chk("mem_dat_hold", o_wb_mem_dat, cap_dat);
            end
            if (o_wb_cpu_ack) begin
               chk("ack_back_to_back", prev_cpu_ack, 0);
               chk("ack_has_expectation", sb.size() > 0, 1);
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  chk("cpu_rdt", o_wb_cpu_rdt, e.rdt);
                  chk("mem_txn_count", slv_starts, e.starts);
                  if (e.hit) chk("hit_latency", wait_c, 1);
                  else       chk("ack_after_mem_ack", prev_mem_ack, 1);
                  if (e.we) begin
                     chk("wr_adr", last_w_adr, e.adr);
                     chk("wr_dat", last_w_dat, e.dat);
                     chk("wr_sel", last_w_sel, e.sel);
                  end else if (!e.hit) begin
                     chk("rd_adr", last_r_adr, e.adr);
                     chk("rd_sel", last_r_sel, 4'hF);
                  end
`ifdef SPI_CACHE_STATS_EN
                  chk("hits",   o_hits, e.hits);
                  chk("misses", o_misses, e.misses);
`endif
               end
               wait_c = 0;
            end else if (i_wb_cpu_cyc) begin
               wait_c++;
            end
         end
         if (tb_done) begin
            chk("queue_drained", sb.size(), 0);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
         end
         prev_rst_low = !rst_n;
         prev_mem_ack = i_wb_mem_ack;
         prev_cpu_ack = o_wb_cpu_ack;
      end
   end

   // ---------------- driver ----------------
   task automatic wait_ack();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n > 3000) begin
            $display("FAIL cpu_ack_timeout: got no ack expected ack within 3000 cycles");
            $fatal(1, "cpu ack timeout");
         end
      end while (!o_wb_cpu_ack);
   endtask

   task automatic do_txn(input logic we, input logic [AW-1:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input bit b2b);
      exp_t        e;
      int          idx;
      logic [31:0] w;
      idx = int'(adr) % LINES;
      e.we = we; e.adr = adr; e.dat = dat; e.sel = sel;
      if (we) begin
         e.hit = 1'b0;
         e.rdt = '0;
         m_starts++;
         w = ref_rd(int'(adr));
         for (int b = 0; b < 4; b++) if (sel[b]) w[8*b +: 8] = dat[8*b +: 8];
         ref_mem[int'(adr)] = w;
      end else begin
         e.hit = line_ok[idx] && (line_adr[idx] == int'(adr));
         e.rdt = ref_rd(int'(adr));
         if (e.hit) begin
            if (m_hits < 65535) m_hits++;
         end else begin
            if (m_misses < 65535) m_misses++;
            m_starts++;
            line_ok[idx]  = 1'b1;
            line_adr[idx] = int'(adr);
         end
      end
      e.starts = m_starts; e.hits = m_hits; e.misses = m_misses;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (!b2b) begin
         i_wb_cpu_cyc = 1'b0;
         repeat ($urandom_range(1, 3)) begin
            @(posedge clk);
            #1;
         end
      end
      i_wb_cpu_adr = adr;
      i_wb_cpu_dat = dat;
      i_wb_cpu_sel = sel;
      i_wb_cpu_we  = we;
      i_wb_cpu_cyc = 1'b1;
      wait_ack();
   endtask

   task automatic reset_during_fill(input logic [AW-1:0] adr);
      int n;
      @(posedge clk);
      #1;
      mem_delay    = 30;
      i_wb_cpu_adr = adr;
      i_wb_cpu_we  = 1'b0;
      i_wb_cpu_sel = 4'hF;
      i_wb_cpu_cyc = 1'b1;
      m_starts++;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n > 100) begin
            $display("FAIL fill_start_timeout: got no mem cyc expected mem cyc");
            $fatal(1, "fill start timeout");
         end
      end while (!o_wb_mem_cyc);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      i_wb_cpu_cyc = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_clear();
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n > 100) begin
            $display("FAIL stray_ack_timeout: got pending expected idle memory");
            $fatal(1, "stray ack timeout");
         end
      end while (slv_pending);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      tb_done      = 1'b0;
      rst_n        = 1'b0;
      i_wb_cpu_adr = '0;
      i_wb_cpu_dat = '0;
      i_wb_cpu_sel = '0;
      i_wb_cpu_we  = 1'b0;
      i_wb_cpu_cyc = 1'b0;
      mem_delay    = 0;
      m_starts     = 0;
      model_clear();
      for (int i = 0; i < LINES; i++) line_adr[i] = 0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);

      // cold miss with a slow downstream, then hit, write-hit merge, re-read
      mem_delay = 40;
      do_txn(1'b0, 22'h000010, 32'h0, 4'hF, 1'b0);
      mem_delay = 3;
      do_txn(1'b0, 22'h000010, 32'h0, 4'hF, 1'b0);
      do_txn(1'b1, 22'h000010, 32'h11223344, 4'b0011, 1'b0);
      do_txn(1'b0, 22'h000010, 32'h0, 4'hF, 1'b0);
      // index-0 conflict evicts both ways
      do_txn(1'b0, 22'h000020, 32'h0, 4'hF, 1'b0);
      do_txn(1'b0, 22'h000010, 32'h0, 4'hF, 1'b0);
      // write to an uncached line does not allocate
      do_txn(1'b1, 22'h000035, 32'hCAFEF00D, 4'hF, 1'b0);
      do_txn(1'b0, 22'h000035, 32'h0, 4'hF, 1'b0);
      // reset mid-fill: abandoned, stray ack ignored, lines invalidated
      reset_during_fill(22'h0003F5);
      mem_delay = 2;
      do_txn(1'b0, 22'h0003F5, 32'h0, 4'hF, 1'b0);
      do_txn(1'b0, 22'h000010, 32'h0, 4'hF, 1'b1);
      do_txn(1'b0, 22'h000010, 32'h0, 4'hF, 1'b1);
      do_txn(1'b0, 22'h0003F5, 32'h0, 4'hF, 1'b1);

      // random mix over a small address pool to get hits and conflicts
      for (int t = 0; t < 400; t++) begin
         mem_delay = $urandom_range(0, 6);
         do_txn($urandom_range(0, 9) < 3, AW'($urandom_range(0, 63)), $urandom,
                4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
      end

      @(posedge clk);
      #1;
      i_wb_cpu_cyc = 1'b0;
      repeat (5) @(negedge clk);
      tb_done = 1'b1;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "global timeout");
   end

endmodule
